// File: rtl/qos_ctrl_pkg.sv
// State encodings and shared constants for the QoS datapath control FSM.
package qos_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/qos_ctrl_fsm_if.sv
// Configuration, FIFO status and state-report bundle between datapath and qos_ctrl_fsm.
interface qos_ctrl_fsm_if #(
    parameter int NUM_FIFOS = 5,
    parameter int NUM_VC    = 2,
    parameter int NUM_D     = 2,
    parameter int UMBRAL_W  = 2
);
    import qos_ctrl_pkg::*;

    logic                         init;
    logic [UMBRAL_W-1:0]          umbral_mf_in;
    logic [NUM_VC*UMBRAL_W-1:0]   umbral_vc_in;
    logic [NUM_D*UMBRAL_W-1:0]    umbral_d_in;
    logic [NUM_FIFOS-1:0]         fifo_empties;
    logic [NUM_FIFOS-1:0]         fifo_errors;

    logic [STATE_W-1:0]           state;
    logic                         idle_out;
    logic                         active_out;
    logic                         error_out;
    logic [UMBRAL_W-1:0]          umbral_mf;
    logic [NUM_VC*UMBRAL_W-1:0]   umbral_vc;
    logic [NUM_D*UMBRAL_W-1:0]    umbral_d;
    logic [NUM_FIFOS-1:0]         error_src;

    modport master (
        output init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
        input  state, idle_out, active_out, error_out, umbral_mf, umbral_vc, umbral_d, error_src
    );

    modport slave (
        input  init, umbral_mf_in, umbral_vc_in, umbral_d_in, fifo_empties, fifo_errors,
        output state, idle_out, active_out, error_out, umbral_mf, umbral_vc, umbral_d, error_src
    );

endinterface

// File: rtl/qos_idle_timer.sv
// Counts consecutive all-empty cycles; expire flags the cycle the count would reach IDLE_HOLD.
module qos_idle_timer #(
    parameter int IDLE_HOLD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic all_empty,
    output logic expire
);
    localparam int CNT_W = (IDLE_HOLD < 1) ? 1 : $clog2(IDLE_HOLD + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_HOLD - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IDLE_HOLD);

    logic [CNT_W-1:0] cnt;

    assign expire = all_empty && !clear && (cnt == LAST);

    // Any non-empty cycle restarts the run; saturate so the count can never wrap.
    always_ff @(posedge clk) begin
        if (reset || clear || !all_empty) begin
            cnt <= '0;
        end else if (cnt != FULL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/qos_ctrl_fsm.sv
// Main control FSM for the QoS TC->VC datapath: threshold latch, IDLE/ACTIVE/ERROR reporting.
// Optional sticky error-source capture is enabled by defining QOS_ERR_CAPTURE_EN.
module qos_ctrl_fsm
    import qos_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = 5,
    parameter int NUM_VC    = 2,
    parameter int NUM_D     = 2,
    parameter int UMBRAL_W  = 2,
    parameter int IDLE_HOLD = 2
) (
    input logic           clk,
    input logic           reset,
    qos_ctrl_fsm_if.slave bus
);

    state_t state_q;
    state_t state_d;

    logic any_err;
    logic all_empty;
    logic hold_clear;
    logic hold_expire;

    logic [UMBRAL_W-1:0]        umbral_mf_q;
    logic [NUM_VC*UMBRAL_W-1:0] umbral_vc_q;
    logic [NUM_D*UMBRAL_W-1:0]  umbral_d_q;

    assign any_err    = |bus.fifo_errors;
    assign all_empty  = &bus.fifo_empties;
    assign hold_clear = (state_q != ST_ACTIVE);

    qos_idle_timer #(
        .IDLE_HOLD (IDLE_HOLD)
    ) u_idle_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (hold_clear),
        .all_empty (all_empty),
        .expire    (hold_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Errors outrank init, init outranks empties/timer; ERROR only leaves through reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (any_err)       state_d = ST_ERROR;
                else if (bus.init) state_d = ST_INIT;
                else               state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (any_err)         state_d = ST_ERROR;
                else if (bus.init)   state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
                else                 state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (any_err)          state_d = ST_ERROR;
                else if (bus.init)    state_d = ST_INIT;
                else if (hold_expire) state_d = ST_IDLE;
                else                  state_d = ST_ACTIVE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Thresholds track the inputs only while in INIT, so the last INIT edge wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            umbral_mf_q <= '0;
            umbral_vc_q <= '0;
            umbral_d_q  <= '0;
        end else if (state_q == ST_INIT) begin
            umbral_mf_q <= bus.umbral_mf_in;
            umbral_vc_q <= bus.umbral_vc_in;
            umbral_d_q  <= bus.umbral_d_in;
        end
    end

`ifdef QOS_ERR_CAPTURE_EN
    logic [NUM_FIFOS-1:0] error_src_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            error_src_q <= '0;
        end else if (state_q == ST_ERROR) begin
            error_src_q <= error_src_q | bus.fifo_errors;
        end else if (state_d == ST_ERROR) begin
            error_src_q <= bus.fifo_errors;
        end
    end

    assign bus.error_src = error_src_q;
`else
    assign bus.error_src = '0;
`endif

    assign bus.state      = state_q;
    assign bus.idle_out   = (state_q == ST_IDLE);
    assign bus.active_out = (state_q == ST_ACTIVE);
    assign bus.error_out  = (state_q == ST_ERROR);
    assign bus.umbral_mf  = umbral_mf_q;
    assign bus.umbral_vc  = umbral_vc_q;
    assign bus.umbral_d   = umbral_d_q;

endmodule

// File: tb/tb_qos_ctrl_fsm.sv
// Directed bench for qos_ctrl_fsm: expected snapshots queued per step, checked one edge later.
module tb_qos_ctrl_fsm;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] mf;
        logic [3:0] vc;
        logic [3:0] d;
        logic [4:0] src;
    } exp_t;

`ifdef QOS_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    qos_ctrl_fsm_if #(.NUM_FIFOS(5), .NUM_VC(2), .NUM_D(2), .UMBRAL_W(2)) bus ();

    qos_ctrl_fsm #(
        .NUM_FIFOS (5),
        .NUM_VC    (2),
        .NUM_D     (2),
        .UMBRAL_W  (2),
        .IDLE_HOLD (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string what, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, expv);
        end
    endtask

    // Queue expectation, advance one edge, then pop and compare against the DUT.
    task automatic step(input string tag, input logic [2:0] st, input logic [1:0] mf,
                        input logic [3:0] vc, input logic [3:0] d, input logic [4:0] src);
        exp_t e;
        string t;
        e.state = st; e.mf = mf; e.vc = vc; e.d = d; e.src = CAP ? src : 5'b0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "state",  {5'b0, bus.state},      {5'b0, e.state});
        cmp(t, "idle",   {7'b0, bus.idle_out},   {7'b0, (e.state == 3'd2)});
        cmp(t, "active", {7'b0, bus.active_out}, {7'b0, (e.state == 3'd3)});
        cmp(t, "error",  {7'b0, bus.error_out},  {7'b0, (e.state == 3'd4)});
        cmp(t, "mf",     {6'b0, bus.umbral_mf},  {6'b0, e.mf});
        cmp(t, "vc",     {4'b0, bus.umbral_vc},  {4'b0, e.vc});
        cmp(t, "d",      {4'b0, bus.umbral_d},   {4'b0, e.d});
        cmp(t, "src",    {3'b0, bus.error_src},  {3'b0, e.src});
    endtask

    initial begin
        reset            = 1'b1;
        bus.init         = 1'b1;
        bus.umbral_mf_in = 2'd1;
        bus.umbral_vc_in = 4'b0110;
        bus.umbral_d_in  = 4'b1111;
        bus.fifo_empties = 5'h1F;
        bus.fifo_errors  = 5'h00;

        // Reset held four cycles with init already requested.
        repeat (3) @(posedge clk);
        step("rst_hold", 3'd0, 2'd0, 4'h0, 4'h0, 5'h00);
        reset = 1'b0;
        step("rst_rel",  3'd1, 2'd0, 4'h0, 4'h0, 5'h00);
        step("init_ld",  3'd1, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.init = 1'b0;
        step("init_out", 3'd2, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.umbral_mf_in = 2'd0; bus.umbral_vc_in = 4'h0; bus.umbral_d_in = 4'h0;
        step("idle_hold_thr", 3'd2, 2'd1, 4'h6, 4'hF, 5'h00);

        // Activity and the two-cycle idle hold.
        bus.fifo_empties = 5'h1E;
        step("act_enter", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.fifo_empties = 5'h1F;
        step("act_empty1", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        step("act_to_idle", 3'd2, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.fifo_empties = 5'h1E;
        step("act_reenter", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.fifo_empties = 5'h1F;
        step("act_e1", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.fifo_empties = 5'h1E;
        step("act_boundary_busy", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.fifo_empties = 5'h1F;
        step("act_restart1", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        step("act_restart2", 3'd2, 2'd1, 4'h6, 4'hF, 5'h00);

        // Re-initialisation from ACTIVE.
        bus.fifo_empties = 5'h1E;
        step("act_again", 3'd3, 2'd1, 4'h6, 4'hF, 5'h00);
        bus.init = 1'b1; bus.umbral_mf_in = 2'd2;
        step("reinit_enter", 3'd1, 2'd1, 4'h6, 4'hF, 5'h00);
        step("reinit_load", 3'd1, 2'd2, 4'h0, 4'h0, 5'h00);
        bus.init = 1'b0; bus.fifo_empties = 5'h1F;
        step("reinit_idle", 3'd2, 2'd2, 4'h0, 4'h0, 5'h00);

        // Error beats simultaneous init; thresholds frozen in ERROR.
        bus.fifo_errors = 5'b01001; bus.init = 1'b1; bus.umbral_mf_in = 2'd3;
        bus.umbral_vc_in = 4'h9; bus.umbral_d_in = 4'h5;
        step("err_enter", 3'd4, 2'd2, 4'h0, 4'h0, 5'b01001);
        bus.fifo_errors = 5'b00000; bus.fifo_empties = 5'h1E;
        step("err_absorb", 3'd4, 2'd2, 4'h0, 4'h0, 5'b01001);
        bus.fifo_errors = 5'b10000;
        step("err_accum", 3'd4, 2'd2, 4'h0, 4'h0, 5'b11001);
        bus.fifo_errors = 5'b00000; bus.init = 1'b0; bus.fifo_empties = 5'h1F;
        step("err_sticky", 3'd4, 2'd2, 4'h0, 4'h0, 5'b11001);

        // Reset from ERROR, then a fresh INIT load.
        reset = 1'b1;
        step("err_rst1", 3'd0, 2'd0, 4'h0, 4'h0, 5'h00);
        repeat (2) @(posedge clk);
        step("err_rst4", 3'd0, 2'd0, 4'h0, 4'h0, 5'h00);
        reset = 1'b0;
        step("err_rst_rel", 3'd1, 2'd0, 4'h0, 4'h0, 5'h00);
        step("init_load2", 3'd2, 2'd3, 4'h9, 4'h5, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
